// File: rtl/inst_queue_pkg.sv
// Shared constants and the entry layout for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam int          IQ_ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
    } iq_entry_t;

    function automatic iq_entry_t packEntry(input logic [31:0] pc,
                                            input logic [31:0] instr,
                                            input logic        excp);
        iq_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.excp  = excp;
        return e;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Show-ahead instruction queue between fetch and decode; presents a NOP word when empty.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_instr,
    input  logic          push_excp,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [31:0]   pop_pc,
    output logic [31:0]   pop_instr,
    output logic          pop_excp,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    iq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    iq_entry_t     headEntry;
    logic          pushFire;
    logic          popFire;
    logic          notEmpty;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign notEmpty   = (count_q != '0);
    assign push_ready = (count_q != FULL_CNT);
    assign pushFire   = push_valid && push_ready && !flush;
    assign popFire    = notEmpty && pop_ready && !flush;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushFire) wrPtr_d = wrPtr_q + 1'b1;
            if (popFire)  rdPtr_d = rdPtr_q + 1'b1;
            if (pushFire && !popFire)      count_d = count_q + 1'b1;
            else if (popFire && !pushFire) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (pushFire) begin
            mem_q[wrPtr_q] <= packEntry(push_pc, push_instr, push_excp);
        end
    end

    always_comb begin
        headEntry = mem_q[rdPtr_q];
        pop_valid = notEmpty;
        pop_pc    = notEmpty ? headEntry.pc    : 32'h0;
        pop_instr = notEmpty ? headEntry.instr : NOP_WORD;
        pop_excp  = notEmpty ? headEntry.excp  : 1'b0;
    end

    assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: reset, fill, wrap, full+pop, flush and exception bundling.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        push_excp;
    logic        pop_valid;
    logic        pop_ready;
    logic [31:0] pop_pc;
    logic [31:0] pop_instr;
    logic        pop_excp;
    logic [2:0]  count;

    int testsRun;
    int testsFailed;
    logic [31:0] expHead;

    inst_queue #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .push_excp  (push_excp),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_pc     (pop_pc),
        .pop_instr  (pop_instr),
        .pop_excp   (pop_excp),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs, clocks once, then leaves the bus idle 1ns after the edge.
    task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic ex, input logic pr, input logic fl);
        push_valid = pv;
        push_pc    = pc;
        push_instr = ins;
        push_excp  = ex;
        pop_ready  = pr;
        flush      = fl;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        push_excp  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        push_pc = '0; push_instr = '0; push_excp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset pop_valid", {31'b0, pop_valid}, 32'd0);
        checkOutput("reset pop_pc", pop_pc, 32'h0);
        checkOutput("reset pop_instr", pop_instr, 32'h0);
        checkOutput("reset pop_excp", {31'b0, pop_excp}, 32'd0);
        checkOutput("reset push_ready", {31'b0, push_ready}, 32'd1);
        checkOutput("reset count", {29'b0, count}, 32'd0);

        // Single push then pop.
        applyStimulus(1'b1, RESET_PC, 32'h2402_0001, 1'b0, 1'b0, 1'b0);
        checkOutput("push1 pop_valid", {31'b0, pop_valid}, 32'd1);
        checkOutput("push1 pop_instr", pop_instr, 32'h2402_0001);
        checkOutput("push1 pop_pc", pop_pc, 32'hBFC0_0000);
        checkOutput("push1 count", {29'b0, count}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("pop1 count", {29'b0, count}, 32'd0);
        checkOutput("pop1 pop_instr", pop_instr, 32'h0);
        checkOutput("pop1 pop_valid", {31'b0, pop_valid}, 32'd0);

        // Pop on empty must not underflow.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("empty pop count", {29'b0, count}, 32'd0);

        // Fill to four entries.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("fill count", {29'b0, count}, 32'd4);
        checkOutput("fill push_ready", {31'b0, push_ready}, 32'd0);
        applyStimulus(1'b1, 32'h2000, 32'hBAD, 1'b0, 1'b0, 1'b0);
        checkOutput("overfill count", {29'b0, count}, 32'd4);
        checkOutput("overfill head pc", pop_pc, 32'h1000);
        checkOutput("overfill head instr", pop_instr, 32'hA0);

        // Full with same-cycle pop: pop fires, push refused.
        applyStimulus(1'b1, 32'h1010, 32'hA4, 1'b0, 1'b1, 1'b0);
        checkOutput("fullpop count", {29'b0, count}, 32'd3);
        checkOutput("fullpop head pc", pop_pc, 32'h1004);
        applyStimulus(1'b1, 32'h1010, 32'hA4, 1'b0, 1'b0, 1'b0);
        checkOutput("refill count", {29'b0, count}, 32'd4);

        // Drain to two entries (head 100C) then stream across pointer wrap.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("drain count", {29'b0, count}, 32'd2);
        expHead = 32'h100C;
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("wrap%0d head pc", k), pop_pc, expHead);
            applyStimulus(1'b1, 32'h1014 + 32'(4 * k), 32'hC0 + 32'(k), 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("wrap%0d count", k), {29'b0, count}, 32'd2);
            expHead = expHead + 32'd4;
        end
        checkOutput("wrap final head pc", pop_pc, 32'h1034);

        // Flush at count 3 with simultaneous push and pop.
        applyStimulus(1'b1, 32'h103C, 32'hCA, 1'b0, 1'b0, 1'b0);
        checkOutput("preflush count", {29'b0, count}, 32'd3);
        applyStimulus(1'b1, 32'hDEAD_0000, 32'hDEAD, 1'b1, 1'b1, 1'b1);
        checkOutput("flush count", {29'b0, count}, 32'd0);
        checkOutput("flush pop_valid", {31'b0, pop_valid}, 32'd0);
        checkOutput("flush pop_instr", pop_instr, 32'h0);
        applyStimulus(1'b1, 32'h3000, 32'h30, 1'b0, 1'b0, 1'b0);
        checkOutput("postflush head pc", pop_pc, 32'h3000);
        checkOutput("postflush count", {29'b0, count}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Exception flag stays bundled with its PC.
        applyStimulus(1'b1, 32'h2F00, 32'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0003, 32'h22, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2F08, 32'h33, 1'b0, 1'b0, 1'b0);
        checkOutput("excp head0 pc", pop_pc, 32'h2F00);
        checkOutput("excp head0 flag", {31'b0, pop_excp}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("excp head1 pc", pop_pc, 32'h0000_0003);
        checkOutput("excp head1 flag", {31'b0, pop_excp}, 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("excp head2 pc", pop_pc, 32'h2F08);
        checkOutput("excp head2 flag", {31'b0, pop_excp}, 32'd0);

        // Reset mid-stream discards the remaining entry.
        rst = 1'b1;
        applyStimulus(1'b1, 32'h4000, 32'h40, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("midreset count", {29'b0, count}, 32'd0);
        checkOutput("midreset pop_valid", {31'b0, pop_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
